// File: rtl/writeback_stage_pkg.sv
// Shared constants for the writeback stage: load funct3 encodings and
// register-file geometry.
package writeback_stage_pkg;

   localparam int REG_COUNT = 32;
   localparam int REG_AW    = 5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_reg_scoreboard.sv
// Per-register pending-write counters: issue increments, commit and squash
// decrement, saturating at both ends, with a sticky overflow flag.
module reg_scoreboard
   import writeback_stage_pkg::*;
#(
   parameter int REG_COUNT = writeback_stage_pkg::REG_COUNT,
   parameter int CNT_W     = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic              cmt_valid,
   input  logic [REG_AW-1:0] cmt_rd,
   input  logic              sq_valid,
   input  logic [REG_AW-1:0] sq_rd,
   input  logic [REG_AW-1:0] q_rs1,
   input  logic [REG_AW-1:0] q_rs2,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              overflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q [REG_COUNT];
   logic [CNT_W-1:0] cnt_d [REG_COUNT];
   logic             ovf_q;
   logic             ovf_set;
   logic             inc, dec_c, dec_s, net_up, net_dn1, net_dn2;

   // Events to the same register sum to a net change of -2..+1.
   always_comb begin
      cnt_d   = cnt_q;
      ovf_set = 1'b0;
      inc     = 1'b0;
      dec_c   = 1'b0;
      dec_s   = 1'b0;
      net_up  = 1'b0;
      net_dn1 = 1'b0;
      net_dn2 = 1'b0;
      cnt_d[0] = '0;
      for (int r = 1; r < REG_COUNT; r++) begin
         inc     = iss_valid && (iss_rd == REG_AW'(r));
         dec_c   = cmt_valid && (cmt_rd == REG_AW'(r));
         dec_s   = sq_valid  && (sq_rd  == REG_AW'(r));
         net_up  = inc && !dec_c && !dec_s;
         net_dn1 = (!inc && (dec_c ^ dec_s)) || (inc && dec_c && dec_s);
         net_dn2 = !inc && dec_c && dec_s;
         if (net_up) begin
            if (cnt_q[r] == CNT_MAX) ovf_set = 1'b1;
            else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
         end else if (net_dn1) begin
            cnt_d[r] = (cnt_q[r] == '0) ? '0 : cnt_q[r] - CNT_ONE;
         end else if (net_dn2) begin
            cnt_d[r] = (cnt_q[r] > CNT_ONE) ? cnt_q[r] - CNT_ONE - CNT_ONE : '0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < REG_COUNT; r++) cnt_q[r] <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_q | ovf_set;
      end
   end

   assign rs1_busy = (q_rs1 != '0) && (cnt_q[q_rs1] != '0);
   assign rs2_busy = (q_rs2 != '0) && (cnt_q[q_rs2] != '0);
   assign overflow = ovf_q;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: captures MEM results, extracts load data and drives
// the register file write port one cycle later; hosts the hazard scoreboard.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int REG_COUNT = writeback_stage_pkg::REG_COUNT,
   parameter int CNT_W     = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic              wb_hold,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_is_load,
   input  logic [2:0]        mem_funct3,
   input  logic [1:0]        mem_addr_lo,
   input  logic [31:0]       mem_result,
   input  logic [31:0]       mem_load_word,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic              sq_valid,
   input  logic [REG_AW-1:0] sq_rd,
   input  logic [REG_AW-1:0] q_rs1,
   input  logic [REG_AW-1:0] q_rs2,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic [REG_AW-1:0] addr_rd,
   output logic [31:0]       data_rd,
   output logic              write_enable,
   output logic              misalign_err,
   output logic              sb_overflow
);

   function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                input logic [1:0]  lo,
                                                input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (lo)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = lo[1] ? w[31:16] : w[15:0];
      case (f3)
         F3_LB:   return {{24{b[7]}}, b};
         F3_LH:   return {{16{h[15]}}, h};
         F3_LBU:  return {24'd0, b};
         F3_LHU:  return {16'd0, h};
         default: return w;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      return ((f3 == F3_LH || f3 == F3_LHU) && lo[0]) || (f3 == F3_LW && lo != 2'd0);
   endfunction

   logic              wb_vld_q, wb_vld_d;
   logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
   logic [31:0]       wb_data_q, wb_data_d;
   logic              wb_mis_q, wb_mis_d;
   logic              accept;

   assign mem_ready = !wb_hold;
   assign accept    = mem_valid && mem_ready;

   // While held, the WB register keeps its contents so the result commits once on release.
   always_comb begin
      wb_vld_d  = wb_vld_q;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      wb_mis_d  = wb_mis_q;
      if (!wb_hold) begin
         wb_vld_d = accept && mem_reg_write && (mem_rd != '0);
         if (accept) begin
            wb_addr_d = mem_rd;
            wb_data_d = mem_is_load ? load_extract(mem_funct3, mem_addr_lo, mem_load_word)
                                    : mem_result;
            wb_mis_d  = mem_is_load && is_misaligned(mem_funct3, mem_addr_lo);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wb_vld_q  <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         wb_mis_q  <= 1'b0;
      end else begin
         wb_vld_q  <= wb_vld_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         wb_mis_q  <= wb_mis_d;
      end
   end

   assign write_enable = wb_vld_q && !wb_hold;
   assign addr_rd      = wb_addr_q;
   assign data_rd      = wb_data_q;
   assign misalign_err = wb_mis_q && write_enable;

   reg_scoreboard #(
      .REG_COUNT (REG_COUNT),
      .CNT_W     (CNT_W)
   ) u_sb (
      .clock     (clock),
      .reset_n   (reset_n),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .cmt_valid (write_enable),
      .cmt_rd    (addr_rd),
      .sq_valid  (sq_valid),
      .sq_rd     (sq_rd),
      .q_rs1     (q_rs1),
      .q_rs2     (q_rs2),
      .rs1_busy  (rs1_busy),
      .rs2_busy  (rs2_busy),
      .overflow  (sb_overflow)
   );

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: table of load/ALU writes plus hand
// sequences for scoreboard, hold, overflow, misalign and reset.
module tb_writeback_stage;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        mem_valid, mem_ready, wb_hold, mem_reg_write, mem_is_load;
   logic [4:0]  mem_rd, iss_rd, sq_rd, q_rs1, q_rs2, addr_rd;
   logic [2:0]  mem_funct3;
   logic [1:0]  mem_addr_lo;
   logic [31:0] mem_result, mem_load_word, data_rd;
   logic        iss_valid, sq_valid, rs1_busy, rs2_busy;
   logic        write_enable, misalign_err, sb_overflow;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   writeback_stage dut (
      .clock(clock), .reset_n(reset_n), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .wb_hold(wb_hold), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
      .mem_is_load(mem_is_load), .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
      .mem_result(mem_result), .mem_load_word(mem_load_word), .iss_valid(iss_valid),
      .iss_rd(iss_rd), .sq_valid(sq_valid), .sq_rd(sq_rd), .q_rs1(q_rs1), .q_rs2(q_rs2),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .addr_rd(addr_rd), .data_rd(data_rd),
      .write_enable(write_enable), .misalign_err(misalign_err), .sb_overflow(sb_overflow)
   );

   typedef struct {
      logic        is_load;
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [31:0] result;
      logic [4:0]  rd;
      logic [31:0] exp_data;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic offer(input logic [4:0] rd, input logic [31:0] res);
      mem_valid = 1'b1; mem_reg_write = 1'b1; mem_is_load = 1'b0;
      mem_rd = rd; mem_result = res;
   endtask

   initial begin
      reset_n = 1'b0; mem_valid = 0; wb_hold = 0; mem_reg_write = 0; mem_is_load = 0;
      mem_rd = 0; mem_funct3 = 0; mem_addr_lo = 0; mem_result = 0;
      mem_load_word = 32'h80FF7F01; iss_valid = 0; iss_rd = 0; sq_valid = 0; sq_rd = 0;
      q_rs1 = 0; q_rs2 = 0;

      vecs[0]  = '{1'b1, 3'b000, 2'd1, 32'h0,        5'd1,  32'h0000007F, 1'b0};
      vecs[1]  = '{1'b1, 3'b000, 2'd3, 32'h0,        5'd2,  32'hFFFFFF80, 1'b0};
      vecs[2]  = '{1'b1, 3'b101, 2'd2, 32'h0,        5'd3,  32'h000080FF, 1'b0};
      vecs[3]  = '{1'b1, 3'b010, 2'd0, 32'h0,        5'd4,  32'h80FF7F01, 1'b0};
      vecs[4]  = '{1'b1, 3'b001, 2'd1, 32'h0,        5'd5,  32'h00007F01, 1'b1};
      vecs[5]  = '{1'b1, 3'b001, 2'd2, 32'h0,        5'd6,  32'hFFFF80FF, 1'b0};
      vecs[6]  = '{1'b1, 3'b100, 2'd0, 32'h0,        5'd7,  32'h00000001, 1'b0};
      vecs[7]  = '{1'b1, 3'b000, 2'd2, 32'h0,        5'd8,  32'hFFFFFFFF, 1'b0};
      vecs[8]  = '{1'b1, 3'b010, 2'd2, 32'h0,        5'd9,  32'h80FF7F01, 1'b1};
      vecs[9]  = '{1'b1, 3'b101, 2'd3, 32'h0,        5'd10, 32'h000080FF, 1'b1};
      vecs[10] = '{1'b0, 3'b000, 2'd1, 32'hDEADBEEF, 5'd31, 32'hDEADBEEF, 1'b0};

      #12;
      chk("rst_we", write_enable, 0);
      chk("rst_addr", addr_rd, 0);
      chk("rst_data", data_rd, 0);
      chk("rst_mis", misalign_err, 0);
      chk("rst_ovf", sb_overflow, 0);
      reset_n = 1'b1;
      step();

      // table: one write per vector, pulse must last exactly one cycle
      for (int i = 0; i < 11; i++) begin
         mem_valid = 1; mem_reg_write = 1; mem_is_load = vecs[i].is_load;
         mem_funct3 = vecs[i].f3; mem_addr_lo = vecs[i].lo;
         mem_result = vecs[i].result; mem_rd = vecs[i].rd;
         step();
         chk($sformatf("v%0d_we", i), write_enable, 1);
         chk($sformatf("v%0d_addr", i), addr_rd, vecs[i].rd);
         chk($sformatf("v%0d_data", i), data_rd, vecs[i].exp_data);
         chk($sformatf("v%0d_mis", i), misalign_err, vecs[i].exp_mis);
         mem_valid = 0;
         step();
         chk($sformatf("v%0d_we_off", i), write_enable, 0);
         chk($sformatf("v%0d_mis_off", i), misalign_err, 0);
      end

      // hazard on x5
      q_rs1 = 5; iss_valid = 1; iss_rd = 5;
      step();
      iss_valid = 0;
      chk("x5_busy_issue", rs1_busy, 1);
      offer(5, 32'h55);
      step();
      mem_valid = 0;
      chk("x5_busy_we", rs1_busy, 1);
      chk("x5_we", write_enable, 1);
      step();
      chk("x5_free", rs1_busy, 0);

      // x7: two issues, one commit
      q_rs2 = 7; iss_valid = 1; iss_rd = 7;
      step(); step();
      iss_valid = 0;
      offer(7, 32'h77);
      step();
      mem_valid = 0;
      step();
      chk("x7_still_busy", rs2_busy, 1);
      offer(7, 32'h78);
      step();
      mem_valid = 0;
      step();
      chk("x7_free", rs2_busy, 0);

      // x3: issue and commit in the same cycle cancel
      q_rs1 = 3; iss_valid = 1; iss_rd = 3;
      step();
      iss_valid = 0;
      offer(3, 32'h33);
      step();
      mem_valid = 0; iss_valid = 1; iss_rd = 3;
      step();
      iss_valid = 0;
      chk("x3_same_cycle", rs1_busy, 1);
      offer(3, 32'h34);
      step();
      mem_valid = 0;
      step();
      chk("x3_free", rs1_busy, 0);

      // x4: commit plus squash from count 2
      q_rs2 = 4; iss_valid = 1; iss_rd = 4;
      step(); step();
      iss_valid = 0;
      offer(4, 32'h44);
      step();
      mem_valid = 0; sq_valid = 1; sq_rd = 4;
      chk("x4_busy_before", rs2_busy, 1);
      step();
      sq_valid = 0;
      chk("x4_double_dec", rs2_busy, 0);

      // x0 never writes, never busy
      offer(0, 32'hFFFF);
      q_rs1 = 0; iss_valid = 1; iss_rd = 0;
      step();
      mem_valid = 0; iss_valid = 0;
      chk("x0_we", write_enable, 0);
      chk("x0_busy", rs1_busy, 0);

      // hold for 3 cycles, held result commits once on release
      offer(10, 32'h1234);
      step();
      wb_hold = 1;
      offer(11, 32'h9999);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("hold%0d_ready", c), mem_ready, 0);
         chk($sformatf("hold%0d_we", c), write_enable, 0);
         step();
      end
      wb_hold = 0; mem_valid = 0;
      #1;
      chk("rel_we", write_enable, 1);
      chk("rel_addr", addr_rd, 10);
      chk("rel_data", data_rd, 32'h1234);
      step();
      chk("rel_once", write_enable, 0);

      // overflow on x9
      q_rs1 = 9; iss_valid = 1; iss_rd = 9;
      step(); step(); step();
      chk("ovf_not_yet", sb_overflow, 0);
      step();
      iss_valid = 0;
      chk("ovf_set", sb_overflow, 1);
      chk("ovf_busy", rs1_busy, 1);
      for (int c = 0; c < 3; c++) begin
         offer(9, 32'h9);
         step();
         mem_valid = 0;
         step();
         chk($sformatf("ovf_drain%0d", c), rs1_busy, (c < 2) ? 1 : 0);
      end
      chk("ovf_sticky", sb_overflow, 1);

      // asynchronous reset mid-stream with a write in flight
      q_rs2 = 12; iss_valid = 1; iss_rd = 12;
      step();
      iss_valid = 0;
      offer(12, 32'hABCD);
      step();
      mem_valid = 0;
      chk("pre_rst_we", write_enable, 1);
      #2 reset_n = 0;
      #1;
      chk("arst_we", write_enable, 0);
      chk("arst_addr", addr_rd, 0);
      chk("arst_data", data_rd, 0);
      chk("arst_ovf", sb_overflow, 0);
      chk("arst_busy12", rs2_busy, 0);
      q_rs1 = 9; #1;
      chk("arst_busy9", rs1_busy, 0);
      @(negedge clock);
      reset_n = 1;
      step();
      chk("post_rst_we", write_enable, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
